// File: rtl/lc2k_mem_pkg.sv
// Shared types and constants for the LC2K data-memory arbiter.
// Default widths match the 64-word memory array.
package lc2k_mem_pkg;

    localparam int DEF_ADDR_W = 6;
    localparam int DEF_DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE,
        ISSUE,
        WAIT,
        RESP
    } state_t;

    typedef logic req_id_t;

    localparam req_id_t REQ_FETCH = 1'b0;
    localparam req_id_t REQ_DATA  = 1'b1;

endpackage

// File: rtl/lc2k_mem_arbiter_rr_arb2.sv
// Combinational two-way round-robin pick between fetch and data.
// A contested pick goes to the requester that was not granted last.
module rr_arb2
    import lc2k_mem_pkg::*;
(
    input  logic    if_req,
    input  logic    dm_req,
    input  req_id_t last_grant,
    output logic    grant_valid,
    output req_id_t grant
);

    always_comb begin
        grant_valid = if_req | dm_req;
        grant       = REQ_FETCH;
        if (if_req && dm_req) begin
            grant = ~last_grant;
        end else if (dm_req) begin
            grant = REQ_DATA;
        end
    end

endmodule

// File: rtl/lc2k_mem_arbiter.sv
// Fetch / load-store arbiter and sequencer for the shared LC2K
// data memory: one fixed-latency access at a time, round-robin.
module lc2k_mem_arbiter
    import lc2k_mem_pkg::*;
#(
    parameter int ADDR_W      = DEF_ADDR_W,
    parameter int DATA_W      = DEF_DATA_W,
    parameter int MEM_LATENCY = 2
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              if_req,
    input  logic [ADDR_W-1:0] if_addr,
    output logic [DATA_W-1:0] if_rdata,
    output logic              if_ready,
    input  logic              dm_req,
    input  logic              dm_we,
    input  logic [ADDR_W-1:0] dm_addr,
    input  logic [DATA_W-1:0] dm_wdata,
    output logic [DATA_W-1:0] dm_rdata,
    output logic              dm_ready,
    output logic              mem_en,
    output logic              mem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata,
    output logic              busy
);

    localparam int CNT_W = $clog2(MEM_LATENCY + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(MEM_LATENCY - 1);

    state_t           state;
    state_t           state_nx;
    logic [CNT_W-1:0] cnt;
    req_id_t          last_grant;
    req_id_t          owner;
    req_id_t          grant;
    logic             grant_valid;
    logic             we_q;

    rr_arb2 u_arb (
        .if_req      (if_req),
        .dm_req      (dm_req),
        .last_grant  (last_grant),
        .grant_valid (grant_valid),
        .grant       (grant)
    );

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        unique case (state)
            IDLE:    if (grant_valid) state_nx = ISSUE;
            ISSUE:   state_nx = WAIT;
            WAIT:    if (cnt == '0) state_nx = RESP;
            RESP:    state_nx = IDLE;
            default: state_nx = IDLE;
        endcase
    end

    // Outputs are registered, so each one is set on entry to its state.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            cnt        <= '0;
            last_grant <= REQ_FETCH;
            owner      <= REQ_FETCH;
            we_q       <= 1'b0;
            mem_en     <= 1'b0;
            mem_we     <= 1'b0;
            mem_addr   <= '0;
            mem_wdata  <= '0;
            if_ready   <= 1'b0;
            dm_ready   <= 1'b0;
            if_rdata   <= '0;
            dm_rdata   <= '0;
            busy       <= 1'b0;
        end else begin
            mem_en   <= 1'b0;
            if_ready <= 1'b0;
            dm_ready <= 1'b0;
            busy     <= (state_nx != IDLE);
            unique case (state)
                IDLE: begin
                    if (grant_valid) begin
                        owner     <= grant;
                        mem_en    <= 1'b1;
                        mem_we    <= (grant == REQ_DATA) && dm_we;
                        we_q      <= (grant == REQ_DATA) && dm_we;
                        mem_addr  <= (grant == REQ_DATA) ? dm_addr : if_addr;
                        mem_wdata <= (grant == REQ_DATA) ? dm_wdata : '0;
                    end
                end
                ISSUE: begin
                    cnt    <= CNT_LOAD;
                    mem_we <= 1'b0;
                end
                WAIT: begin
                    if (cnt == '0) begin
                        if (owner == REQ_FETCH) begin
                            if_rdata <= mem_rdata;
                            if_ready <= 1'b1;
                        end else begin
                            if (!we_q) dm_rdata <= mem_rdata;
                            dm_ready <= 1'b1;
                        end
                    end else begin
                        cnt <= cnt - CNT_W'(1);
                    end
                end
                RESP: begin
                    last_grant <= owner;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: doc/lc2k_mem_arbiter.md
# lc2k_mem_arbiter

Two-requester arbiter and access sequencer for the LC2K data memory. It lets the instruction-fetch path and the load/store path share one single-port, fixed-latency 64-word memory. It serialises requests, chooses between simultaneous requesters round-robin, drives one memory access at a time, and returns read data with a one-cycle ready pulse to the winner. It sits between the CPU core's fetch/MEM stages and the memory array.

## Interface

Clock is `clk`. Reset is `reset`, asynchronous and active-high. The block has one clock domain.

Parameters:
- `ADDR_W`, default 6: word-address width (64 words).
- `DATA_W`, default 32: data width.
- `MEM_LATENCY`, default 2: cycles from the memory issue cycle to valid `mem_rdata`. Must be ≥1.

Ports:
- `clk`  in  1  system clock.
- `reset`  in  1  asynchronous active-high reset.
- `if_req`  in  1  fetch request; level, held until `if_ready`.
- `if_addr`  in  ADDR_W  fetch word address; stable while `if_req` is high.
- `if_rdata`  out  DATA_W  fetched word; valid while `if_ready` is high.
- `if_ready`  out  1  one-cycle completion pulse to fetch.
- `dm_req`  in  1  load/store request; level, held until `dm_ready`.
- `dm_we`  in  1  1 = store, 0 = load.
- `dm_addr`  in  ADDR_W  load/store word address.
- `dm_wdata`  in  DATA_W  store data (regB value).
- `dm_rdata`  out  DATA_W  load data; valid while `dm_ready` is high.
- `dm_ready`  out  1  one-cycle completion pulse to load/store.
- `mem_en`  out  1  memory access strobe; exactly one cycle per access.
- `mem_we`  out  1  memory write enable; qualified by `mem_en`.
- `mem_addr`  out  ADDR_W  memory address.
- `mem_wdata`  out  DATA_W  memory write data.
- `mem_rdata`  in  DATA_W  memory read data; valid `MEM_LATENCY` cycles after the `mem_en` cycle.
- `busy`  out  1  high in every state except IDLE.

## Operation

- FSM states: IDLE, ISSUE, WAIT, RESP.
- IDLE: if any request is high, latch the winner's ID, address, we and wdata, then go to ISSUE. Otherwise stay in IDLE.
- Arbitration happens only in IDLE. With a single requester, that requester wins. With both requesters, the one not granted last time wins. `last_grant` resets to FETCH, so the first contested grant goes to DATA.
- ISSUE (1 cycle): `mem_en`=1, and `mem_we`/`mem_addr`/`mem_wdata` carry the latched values. Load the counter with `MEM_LATENCY`-1, then go to WAIT.
- WAIT: decrement the counter. When the counter is 0, capture `mem_rdata` into the winner's rdata register (loads and fetches only) and go to RESP.
- RESP (1 cycle): assert the winner's ready, update `last_grant`, then go to IDLE.
- Store: ready is pulsed in RESP as for a load. `dm_rdata` keeps its previous value.
- `if_rdata`/`dm_rdata` are registered and hold their value until the next completed read to that port.
- A requester must deassert req in the cycle after its ready pulse. If req is still high in IDLE, that is a new request.
- Requests raised during ISSUE/WAIT/RESP are not lost; they are evaluated in the next IDLE.
- Fetch requests never write: `mem_we`=0 whenever the fetch port is granted.

## Timing

- Reset values: `mem_en`, `mem_we`, `mem_addr`, `mem_wdata`, `if_ready`, `dm_ready`, `if_rdata`, `dm_rdata` and `busy` are all 0. State is IDLE, counter is 0, `last_grant` is FETCH.
- All outputs are registered.
- Latency: req seen high in IDLE at cycle 0 → `mem_en` at cycle 1 → rdata captured at the end of cycle 1+`MEM_LATENCY` → ready at cycle 2+`MEM_LATENCY`. The default gives ready at cycle 4.
- Throughput: one access per `MEM_LATENCY`+3 cycles. With both ports saturated, grants alternate strictly.
- The counter is sized `$clog2(MEM_LATENCY+1)`. With `MEM_LATENCY`=1, WAIT lasts exactly one cycle.
- Reset mid-access: the FSM returns to IDLE immediately. No ready is issued and the access is not retried. A store whose ISSUE cycle already occurred may have been committed.

## Structure

- Package `lc2k_mem_pkg` holds:
  - the state enum (IDLE/ISSUE/WAIT/RESP);
  - requester ID constants (REQ_FETCH=0, REQ_DATA=1);
  - default `ADDR_W`/`DATA_W` localparams shared with the memory array.
- One sub-module, `rr_arb2`: a combinational 2-way round-robin pick from (`if_req`, `dm_req`, `last_grant`) producing a grant ID. The FSM, counter and registers stay in the top module.

## Test plan

- Reset, then fetch-only request with addr 7 and memory word 7 = 5: `mem_en` is high at cycle 1 only, `if_ready` is high at cycle 4, and `if_rdata`=5.
- Store addr 10 with wdata 0xFFFFFFFF, then load addr 10: one `mem_en` with `mem_we`=1; `dm_ready` pulses; the load returns 0xFFFFFFFF; `dm_rdata` is unchanged after the store.
- `if_req` and `dm_req` asserted in the same cycle after reset: DATA is served first and FETCH second. With both held saturated, the grants alternate D,F,D,F.
- Fetch raised during a data access's WAIT state: it is served in the next IDLE, and its `mem_en` comes 5 cycles after the data `mem_en`.
- `reset` asserted during WAIT: all outputs are 0 in the same cycle and no ready pulse follows. A new request after reset completes normally.
- Repeat the first scenario with `MEM_LATENCY`=1 and 4: ready arrives at cycles 3 and 6 respectively.
